muldiv_unit: RTL and testbench

- Execute-stage HI/LO arithmetic unit for the 5-stage MIPS pipeline.
- Consumes the MULT/MULTU/DIV/DIVU operations issued by decode, together with forwarded rs/rt operands.
- Computes 64-bit products and 32-bit quotient/remainder pairs over multiple cycles and holds the architectural HI and LO registers.
- Exposes `busy` so hazard logic can stall MFHI/MFLO and any new multiply/divide.

---
 rtl/muldiv_unit_pkg.sv | 38 +++
 rtl/muldiv_unit_if.sv | 33 +++
 rtl/muldiv_sign_fix.sv | 47 ++++
 rtl/muldiv_unit.sv | 203 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the execute-stage HI/LO multiply/divide unit:
//   - md_op_e      : MULT/MULTU/DIV/DIVU encodings issued by decode
//   - md_state_e   : sequencer states (IDLE -> ITER -> FIX -> IDLE)
//   - md_op_bus_t  : decoded operation attributes (divide? signed?)
//   - MD_CNT_W     : width of the iteration step counter
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

  localparam int MD_CNT_W = 5;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_MULU = 2'd1,
    MD_DIV  = 2'd2,
    MD_DIVU = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } md_op_bus_t;

  function automatic md_op_bus_t md_decode(input md_op_e op);
    md_op_bus_t d;
    d.is_div    = (op == MD_DIV) || (op == MD_DIVU);
    d.is_signed = (op == MD_MUL) || (op == MD_DIV);
    return d;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// Issue/result bundle between decode/hazard logic and the HI/LO unit.
//   start, op, a, b, cancel : issue side (driven by the master)
//   busy, done, hi, lo      : status and architectural HI/LO (driven by slave)
// Parameter XLEN: operand and HI/LO width.
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int XLEN = 32
) ();
  import muldiv_unit_pkg::*;

  logic            start;
  md_op_e          op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            cancel;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// -----------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational sign-correction stage used in FIX, shared by the multiply and
// divide result paths.
//   is_div_i   : 1 = quotient/remainder pair, 0 = 2*XLEN-bit product
//   neg_res_i  : negate the product (mul) or the quotient (div)
//   neg_rem_i  : negate the remainder (div only)
//   raw_hi_i   : product high half, or unsigned remainder
//   raw_lo_i   : product low half, or unsigned quotient
//   hi_o, lo_o : signed-corrected values destined for HI/LO
// -----------------------------------------------------------------------------
module muldiv_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic            neg_res_i,
  input  logic            neg_rem_i,
  input  logic [XLEN-1:0] raw_hi_i,
  input  logic [XLEN-1:0] raw_lo_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_neg;
  logic [XLEN-1:0]   quo_neg;
  logic [XLEN-1:0]   rem_neg;

  assign prod     = {raw_hi_i, raw_lo_i};
  assign prod_neg = -prod;
  assign quo_neg  = -raw_lo_i;
  assign rem_neg  = -raw_hi_i;

  // NOTE: every output gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    hi_o = raw_hi_i;
    lo_o = raw_lo_i;
    if (is_div_i) begin
      if (neg_res_i) lo_o = quo_neg;
      if (neg_rem_i) hi_o = rem_neg;
    end else if (neg_res_i) begin
      {hi_o, lo_o} = prod_neg;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Execute-stage HI/LO arithmetic unit for the 5-stage MIPS pipeline.
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring shift-subtract) on
// operand magnitudes over 32 ITER cycles, then fixes signs in FIX and writes
// the architectural HI/LO registers.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (forces IDLE, clears HI/LO)
//   bus  : muldiv_unit_if.slave
//          start/op/a/b issue an operation (sampled only in IDLE),
//          cancel aborts an in-flight one (and suppresses start in IDLE),
//          busy = operation in flight, done = one-cycle pulse after HI/LO
//          were written, hi/lo = architectural registers.
//
// Build option:
//   MULDIV_FAST_MUL_EN : MUL/MULU complete at the accepting edge through a
//                        single-cycle XLEN x XLEN multiplier; busy never
//                        asserts for multiplies. Division is unchanged.
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  md_state_e             state_q;
  logic [MD_CNT_W-1:0]   cnt_q;
  logic                  is_div_q;
  logic                  neg_res_q;
  logic                  neg_rem_q;
  logic [XLEN-1:0]       opb_q;     // divisor, or multiplicand magnitude
  logic [XLEN-1:0]       hi_acc_q;  // partial remainder, or product high half
  logic [XLEN-1:0]       lo_acc_q;  // dividend->quotient, or multiplier->product low
  logic [XLEN-1:0]       hi_q;
  logic [XLEN-1:0]       lo_q;
  logic                  done_q;

  // ---------------------------------------------------------------------------
  // Issue-side decode: magnitudes and result signs
  // ---------------------------------------------------------------------------
  md_op_bus_t      dec;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  assign dec   = md_decode(bus.op);
  assign neg_a = dec.is_signed & bus.a[XLEN-1];
  assign neg_b = dec.is_signed & bus.b[XLEN-1];
  assign mag_a = neg_a ? -bus.a : bus.a;
  assign mag_b = neg_b ? -bus.b : bus.b;

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;  // 33-bit partial remainder after the shift-in
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] hi_step;
  logic [XLEN-1:0] lo_step;

  assign mul_sum   = {1'b0, hi_acc_q} + (lo_acc_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {hi_acc_q, lo_acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};

  always_comb begin
    hi_step = hi_acc_q;
    lo_step = lo_acc_q;
    if (is_div_q) begin
      // A clear borrow bit means the divisor fits: keep the difference and
      // shift in a 1; otherwise restore and shift in a 0.
      if (!div_diff[XLEN]) begin
        hi_step = div_diff[XLEN-1:0];
        lo_step = {lo_acc_q[XLEN-2:0], 1'b1};
      end else begin
        hi_step = div_shift[XLEN-1:0];
        lo_step = {lo_acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      // The product grows in from the top while the consumed multiplier bits
      // shift out at the bottom of the low half.
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_acc_q[XLEN-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Sign correction used in FIX
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] fix_hi;
  logic [XLEN-1:0] fix_lo;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .is_div_i  (is_div_q),
    .neg_res_i (neg_res_q),
    .neg_rem_i (neg_rem_q),
    .raw_hi_i  (hi_acc_q),
    .raw_lo_i  (lo_acc_q),
    .hi_o      (fix_hi),
    .lo_o      (fix_lo)
  );

`ifdef MULDIV_FAST_MUL_EN
  // Extending both operands to 2*XLEN (sign- or zero-) makes one truncated
  // unsigned multiply correct for both MUL and MULU.
  logic [2*XLEN-1:0] ext_a;
  logic [2*XLEN-1:0] ext_b;
  logic [2*XLEN-1:0] fast_prod;

  assign ext_a     = {{XLEN{neg_a}}, bus.a};
  assign ext_b     = {{XLEN{neg_b}}, bus.b};
  assign fast_prod = ext_a * ext_b;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opb_q     <= '0;
      hi_acc_q  <= '0;
      lo_acc_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.cancel) begin
            cnt_q    <= '0;
            is_div_q <= dec.is_div;
`ifdef MULDIV_FAST_MUL_EN
            if (!dec.is_div) begin
              hi_q   <= fast_prod[2*XLEN-1:XLEN];
              lo_q   <= fast_prod[XLEN-1:0];
              done_q <= 1'b1;
            end else
`endif
            if (dec.is_div && (bus.b == '0)) begin
              // Divide by zero: preload the architectural result and let
              // FIX pass it through uncorrected.
              neg_res_q <= 1'b0;
              neg_rem_q <= 1'b0;
              hi_acc_q  <= bus.a;
              lo_acc_q  <= '1;
              opb_q     <= '0;
              state_q   <= ST_FIX;
            end else begin
              neg_res_q <= neg_a ^ neg_b;
              neg_rem_q <= neg_a;
              hi_acc_q  <= '0;
              lo_acc_q  <= dec.is_div ? mag_a : mag_b;
              opb_q     <= dec.is_div ? mag_b : mag_a;
              state_q   <= ST_ITER;
            end
          end
        end
        ST_ITER: begin
          if (bus.cancel) begin
            state_q <= ST_IDLE;
          end else begin
            hi_acc_q <= hi_step;
            lo_acc_q <= lo_step;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == MD_CNT_W'(XLEN - 1)) state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!bus.cancel) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: a vector table, hand-written
// sequences for start-while-busy, cancel, reset mid-operation and
// cancel+start in IDLE, then random operations against a plain-arithmetic
// reference model. Honours MULDIV_FAST_MUL_EN for expected multiply timing.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference results straight from the architectural definition.
  function automatic void model(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint          sa;
    longint          sb;
    longint          sp;
    longint          q;
    longint          r;
    longint unsigned up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    hi = '0;
    lo = '0;
    case (o)
      MD_MUL: begin
        sp = sa * sb;
        hi = sp[63:32];
        lo = sp[31:0];
      end
      MD_MULU: begin
        up = {32'h0, a} * {32'h0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b == 32'h0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (o == MD_DIV) begin
          q  = sa / sb;
          r  = sa % sb;
          hi = r[31:0];
          lo = q[31:0];
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
      default: ;
    endcase
  endfunction

  // Cycle (counting the start cycle as 0) in which done is expected.
  function automatic int exp_done_cycle(input md_op_e o, input logic [31:0] b);
    if ((o == MD_DIV || o == MD_DIVU) && b == 32'h0) return 2;
`ifdef MULDIV_FAST_MUL_EN
    if (o == MD_MUL || o == MD_MULU) return 1;
`endif
    return 34;
  endfunction

  // Entered and left at a falling edge; leaves in the done cycle so the next
  // call issues back-to-back with done.
  task automatic run_op(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output int busy_cnt);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = a;
    bus.b     = b;
    done_cyc  = -1;
    busy_cnt  = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cyc = n;
        break;
      end
    end
  endtask

  vec_t vecs[10];

  initial begin
    int          dc;
    int          bc;
    int          cnt;
    int          done_seen;
    logic [31:0] eh;
    logic [31:0] el;
    md_op_e      ro;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{MD_DIV,  32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[1] = '{MD_DIVU, 32'hFFFF_FFFF,  32'd16,        32'h0000_000F, 32'h0FFF_FFFF};
    vecs[2] = '{MD_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[3] = '{MD_MUL,  32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[4] = '{MD_MULU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[5] = '{MD_DIV,  32'd9,          32'h0,         32'h0000_0009, 32'hFFFF_FFFF};
    vecs[6] = '{MD_DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[7] = '{MD_DIVU, 32'd100,        32'd7,         32'h0000_0002, 32'h0000_000E};
    vecs[8] = '{MD_MUL,  32'd2,          32'd3,         32'h0000_0000, 32'h0000_0006};
    vecs[9] = '{MD_DIVU, 32'd5,          32'h0,         32'h0000_0005, 32'hFFFF_FFFF};

    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = MD_MUL;
    bus.a      = '0;
    bus.b      = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hi",   64'(bus.hi),   64'd0);
    check("reset lo",   64'(bus.lo),   64'd0);

    // Vector table, issued back-to-back
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, dc, bc);
      check($sformatf("vec%0d hi", i), 64'(bus.hi), 64'(vecs[i].exp_hi));
      check($sformatf("vec%0d lo", i), 64'(bus.lo), 64'(vecs[i].exp_lo));
      check($sformatf("vec%0d done cycle", i), 64'(dc), 64'(exp_done_cycle(vecs[i].op, vecs[i].b)));
      check($sformatf("vec%0d busy cycles", i), 64'(bc), 64'(exp_done_cycle(vecs[i].op, vecs[i].b) - 1));
    end
    @(negedge clk);
    check("done one cycle", 64'(bus.done), 64'd0);

    // start held high while busy: only the first operation takes effect
    bus.start = 1'b1;
    bus.op    = MD_DIVU;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    dc = -1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.op = MD_MULU;
        bus.a  = 32'd1000;
        bus.b  = 32'd3;
      end
      if (n == 20) bus.start = 1'b0;
      if (bus.done) begin
        dc = n;
        break;
      end
    end
    check("held start done cycle", 64'(dc), 64'd34);
    check("held start hi", 64'(bus.hi), 64'h2);
    check("held start lo", 64'(bus.lo), 64'hE);

    // Cancel in ITER
    run_op(MD_MUL, 32'd2, 32'd3, dc, bc);
    check("cancel pre lo", 64'(bus.lo), 64'd6);
    bus.start = 1'b1;
    bus.op    = MD_DIV;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
      if (n == 10) bus.cancel = 1'b1;
    end
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel busy", 64'(bus.busy), 64'd0);
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    check("cancel no done", 64'(done_seen), 64'd0);
    check("cancel hi", 64'(bus.hi), 64'd0);
    check("cancel lo", 64'(bus.lo), 64'd6);

    // Reset in the middle of an operation
    bus.start = 1'b1;
    bus.op    = MD_DIV;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
      if (n == 20) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst done", 64'(bus.done), 64'd0);
    check("midrst hi",   64'(bus.hi),   64'd0);
    check("midrst lo",   64'(bus.lo),   64'd0);
    run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, dc, bc);
    check("post rst done cycle", 64'(dc), 64'd34);
    check("post rst hi", 64'(bus.hi), 64'h1);
    check("post rst lo", 64'(bus.lo), 64'hFFFF_FFFD);

    // cancel together with start in IDLE: nothing is accepted
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = MD_MUL;
    bus.a      = 32'd5;
    bus.b      = 32'd5;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("cancel+start busy", 64'(bus.busy), 64'd0);
    check("cancel+start done", 64'(bus.done), 64'd0);
    @(negedge clk);
    check("cancel+start busy later", 64'(bus.busy), 64'd0);
    check("cancel+start hi", 64'(bus.hi), 64'h1);
    check("cancel+start lo", 64'(bus.lo), 64'hFFFF_FFFD);

    // Random operations against the reference model
    for (int i = 0; i < 30; i++) begin
      ro  = md_op_e'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = $urandom();
      cnt = $urandom_range(0, 9);
      if (cnt == 0) rb = 32'h0;
      else if (cnt == 1) rb = $urandom_range(1, 15);
      else if (cnt == 2) rb = 32'hFFFF_FFFF;
      else if (cnt == 3) ra = 32'h8000_0000;
      model(ro, ra, rb, eh, el);
      run_op(ro, ra, rb, dc, bc);
      check($sformatf("rand%0d op%0d %0h,%0h hi", i, ro, ra, rb), 64'(bus.hi), 64'(eh));
      check($sformatf("rand%0d op%0d %0h,%0h lo", i, ro, ra, rb), 64'(bus.lo), 64'(el));
      check($sformatf("rand%0d done cycle", i), 64'(dc), 64'(exp_done_cycle(ro, rb)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
